// File: rtl/sum_uart_pkg.sv
// Shared state encoding and ASCII constants for the sum-to-UART framing path.
`timescale 1ns/1ps
package sum_uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps one 4-bit nibble to its uppercase ASCII hex digit.
`timescale 1ns/1ps
module nibble_to_ascii
  import sum_uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = (nibble < 4'd10) ? (ASCII_0 + {4'd0, nibble})
                                  : (ASCII_A - 8'd10 + {4'd0, nibble});

endmodule

// File: rtl/sum_tx_framer.sv
// Frames a sum word as uppercase ASCII hex, MSB nibble first, one byte per UART TX handshake.
// Define SUM_TX_CRLF_EN to append a CR/LF terminator to every frame.
`timescale 1ns/1ps
module sum_tx_framer
  import sum_uart_pkg::*;
#(
  parameter int SUM_WIDTH    = 16,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SUM_WIDTH-1:0]    sum_data,
  input  logic                    sum_valid,
  output logic                    sum_ready,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy,
  output logic                    frame_done,
  output logic [7:0]              drop_count
);

  localparam int DIGITS = SUM_WIDTH / 4;
`ifdef SUM_TX_CRLF_EN
  localparam int FRAME_LEN = DIGITS + 2;
`else
  localparam int FRAME_LEN = DIGITS;
`endif
  localparam int IDX_W = $clog2(DIGITS + 2) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [SUM_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]     byte_idx;
  logic [7:0]           hex_byte;
  logic [7:0]           cur_byte;

  nibble_to_ascii u_hex (
    .nibble (shift_q[SUM_WIDTH-1 -: 4]),
    .ascii  (hex_byte)
  );

`ifdef SUM_TX_CRLF_EN
  always_comb begin
    if (byte_idx < IDX_W'(DIGITS))       cur_byte = hex_byte;
    else if (byte_idx == IDX_W'(DIGITS)) cur_byte = ASCII_CR;
    else                                 cur_byte = ASCII_LF;
  end
`else
  assign cur_byte = hex_byte;
`endif

  // tx_en is decoded from state, so an asynchronous reset drops it without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt  = state;
    sum_ready  = 1'b0;
    tx_en      = 1'b0;
    tx_data    = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        sum_ready = 1'b1;
        if (sum_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        tx_data = PAYLOAD_BITS'(cur_byte);
        if (!tx_busy) begin
          tx_en     = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tx_data = PAYLOAD_BITS'(cur_byte);
        if (tx_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        tx_data = PAYLOAD_BITS'(cur_byte);
        if (!tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      byte_idx   <= '0;
      drop_count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      if (state == IDLE && sum_valid) begin
        shift_q  <= sum_data;
        byte_idx <= '0;
      end else if (state == WAIT_LO && !tx_busy) begin
        shift_q  <= shift_q << 4;
        byte_idx <= byte_idx + 1'b1;
      end
      if (sum_valid && !sum_ready && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sum_tx_framer.sv
// Self-checking bench for sum_tx_framer: behavioural UART TX model plus a hex-string reference.
`timescale 1ns/1ps
module tb_sum_tx_framer;

  localparam int SUM_WIDTH   = 16;
  localparam int DIGITS      = SUM_WIDTH / 4;
`ifdef SUM_TX_CRLF_EN
  localparam int FRAME_LEN   = DIGITS + 2;
`else
  localparam int FRAME_LEN   = DIGITS;
`endif
  localparam int BUSY_CYCLES = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [SUM_WIDTH-1:0] sum_data = '0;
  logic                 sum_valid = 1'b0;
  logic                 sum_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 frame_done;
  logic [7:0]           drop_count;

  sum_tx_framer #(.SUM_WIDTH(SUM_WIDTH), .PAYLOAD_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sum_data   (sum_data),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transmitter model: samples tx_en, raises busy one cycle later for BUSY_CYCLES cycles.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         en_cnt = 0;
  int         viol_cnt = 0;
  int         busy_cnt = 0;
  logic       pend = 1'b0;
  logic       ext_busy = 1'b0;
  logic       hold_chk = 1'b1;
  logic [7:0] hold_byte = 8'h00;

  assign tx_busy = (busy_cnt != 0) || ext_busy;

  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (tx_en) begin
      en_cnt <= en_cnt + 1;
      if (tx_busy || pend) viol_cnt <= viol_cnt + 1;
      rx_q.push_back(tx_data);
      hold_byte <= tx_data;
      pend <= 1'b1;
    end else begin
      pend <= 1'b0;
    end
    if (pend) busy_cnt <= BUSY_CYCLES;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (hold_chk && !reset && (pend || busy_cnt > 0) && tx_data !== hold_byte)
      viol_cnt <= viol_cnt + 1;
  end

  // Reference: the word printed as uppercase hex, most significant digit first.
  task automatic push_expected(input logic [SUM_WIDTH-1:0] w);
    for (int d = DIGITS - 1; d >= 0; d--) begin
      int n;
      n = int'(w[4*d +: 4]);
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
`ifdef SUM_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a word at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input logic [SUM_WIDTH-1:0] w, output bit ok);
    ok = 1'b0;
    sum_data  = w;
    sum_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (sum_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (sum_ready !== 1'b1 || tx_en !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready/en/done=%b%b%b expected 100", sum_ready, tx_en, frame_done);
    end
    vectors++;
    if (tx_data !== 8'h00 || drop_count !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: tx_data=%h drop=%h expected 00 00", tx_data, drop_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_frame(input logic [SUM_WIDTH-1:0] w, input bit chk_drop);
    int base_done, base_en, base_viol;
    bit ok;
    rx_q.delete();
    exp_q.delete();
    push_expected(w);
    base_done = done_cnt;
    base_en   = en_cnt;
    base_viol = viol_cnt;
    offer(w, ok);
    sum_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL frame_accept: word %h not accepted within budget", w);
    end
    wait_done(base_done + 1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL frame_done_timeout: word %h got no frame_done", w);
    end
    tick(3);
    vectors++;
    if (rx_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL frame_len %h: got %0d bytes expected %0d", w, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL frame_byte %h[%0d]: got %h expected %h", w, i, got, exp_q[i]);
      end
    end
    vectors++;
    if (en_cnt - base_en != FRAME_LEN || done_cnt - base_done != 1) begin
      miscompares++;
      $display("FAIL frame_strobes %h: tx_en=%0d done=%0d expected %0d 1",
               w, en_cnt - base_en, done_cnt - base_done, FRAME_LEN);
    end
    vectors++;
    if (viol_cnt != base_viol) begin
      miscompares++;
      $display("FAIL frame_protocol %h: %0d handshake violations expected 0", w, viol_cnt - base_viol);
    end
    if (chk_drop) begin
      vectors++;
      if (drop_count !== 8'h00) begin
        miscompares++;
        $display("FAIL frame_drop %h: drop_count=%h expected 00", w, drop_count);
      end
    end
  endtask

  task automatic test_back_to_back;
    int base_done, base_en;
    bit ok;
    rx_q.delete();
    exp_q.delete();
    push_expected(16'h0000);
    push_expected(16'hFFFF);
    base_done = done_cnt;
    base_en   = en_cnt;
    offer(16'h0000, ok);
    sum_data = 16'hFFFF;
    wait_done(base_done + 1, ok);
    vectors++;
    if (!ok || rx_q.size() != FRAME_LEN) begin
      miscompares++;
      $display("FAIL b2b_first: done=%0d bytes=%0d expected 1 %0d", ok, rx_q.size(), FRAME_LEN);
    end
    offer(16'hFFFF, ok);
    sum_valid = 1'b0;
    wait_done(base_done + 2, ok);
    tick(3);
    vectors++;
    if (!ok || rx_q.size() != 2 * FRAME_LEN) begin
      miscompares++;
      $display("FAIL b2b_len: done=%0d bytes=%0d expected 1 %0d", ok, rx_q.size(), 2 * FRAME_LEN);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got, exp_q[i]);
      end
    end
    vectors++;
    if (en_cnt - base_en != 2 * FRAME_LEN) begin
      miscompares++;
      $display("FAIL b2b_strobes: tx_en=%0d expected %0d", en_cnt - base_en, 2 * FRAME_LEN);
    end
  endtask

  task automatic test_busy_block;
    logic [SUM_WIDTH-1:0] w;
    int base_en, base_done, base_viol;
    bit ok;
    w = SUM_WIDTH'($urandom);
    rx_q.delete();
    exp_q.delete();
    push_expected(w);
    ext_busy = 1'b1;
    tick(2);
    base_en   = en_cnt;
    base_done = done_cnt;
    base_viol = viol_cnt;
    offer(w, ok);
    sum_valid = 1'b0;
    tick(20);
    vectors++;
    if (!ok || en_cnt != base_en) begin
      miscompares++;
      $display("FAIL busy_block: accepted=%0d tx_en=%0d expected 1 0", ok, en_cnt - base_en);
    end
    ext_busy = 1'b0;
    wait_done(base_done + 1, ok);
    tick(3);
    vectors++;
    if (!ok || rx_q.size() != FRAME_LEN || viol_cnt != base_viol) begin
      miscompares++;
      $display("FAIL busy_frame: done=%0d bytes=%0d viol=%0d expected 1 %0d 0",
               ok, rx_q.size(), viol_cnt - base_viol, FRAME_LEN);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL busy_byte[%0d]: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_drop_saturate;
    logic [SUM_WIDTH-1:0] w;
    int base_done, base_viol;
    bit ok;
    w = SUM_WIDTH'($urandom);
    rx_q.delete();
    exp_q.delete();
    push_expected(w);
    base_done = done_cnt;
    base_viol = viol_cnt;
    offer(w, ok);
    tick(300);
    sum_valid = 1'b0;
    tick(150);
    vectors++;
    if (drop_count !== 8'hFF) begin
      miscompares++;
      $display("FAIL drop_saturate: drop_count=%h expected ff", drop_count);
    end
    vectors++;
    if (!ok || rx_q.size() == 0 || rx_q.size() % FRAME_LEN != 0 ||
        done_cnt - base_done != rx_q.size() / FRAME_LEN || viol_cnt != base_viol) begin
      miscompares++;
      $display("FAIL drop_frames: bytes=%0d frames=%0d viol=%0d expected whole frames, 0 viol",
               rx_q.size(), done_cnt - base_done, viol_cnt - base_viol);
    end
    for (int i = 0; i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== exp_q[i % FRAME_LEN]) begin
        miscompares++;
        $display("FAIL drop_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i % FRAME_LEN]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int base_done;
    bit ok;
    rx_q.delete();
    base_done = done_cnt;
    offer(16'h1234, ok);
    sum_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx_q.size() == 2 && busy_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midreset_reach: second byte busy not seen, bytes=%0d", rx_q.size());
    end
    tick(2);
    hold_chk = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (tx_en !== 1'b0 || sum_ready !== 1'b1 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: en/ready/done=%b%b%b expected 010", tx_en, sum_ready, frame_done);
    end
    vectors++;
    if (drop_count !== 8'h00 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_data: drop=%h tx_data=%h expected 00 00", drop_count, tx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(30);
    hold_chk = 1'b1;
    vectors++;
    if (done_cnt != base_done) begin
      miscompares++;
      $display("FAIL midreset_nodone: frame_done count %0d expected 0", done_cnt - base_done);
    end
    test_frame(16'h00AB, 1'b1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame(16'h1A2F, 1'b1);
    for (int k = 0; k < 3; k++) test_frame(SUM_WIDTH'($urandom), 1'b1);
    test_back_to_back();
    test_busy_block();
    test_drop_saturate();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_tx_framer.md
Name: sum_tx_framer

Overview:
Upstream feeder for the UART transmitter. Accepts a latched sum word over a valid/ready handshake and converts it to uppercase ASCII hex digits, MSB nibble first. Issues one byte at a time to the transmitter using its enable/busy handshake. Sits between the sum-latch datapath and the UART TX serializer.

Parameters:
SUM_WIDTH, 16, width of input sum; must be a multiple of 4 and ≥4.
PAYLOAD_BITS, 8, byte width presented to the transmitter; fixed at 8 for ASCII.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
sum_data  in  SUM_WIDTH  sum word to transmit.
sum_valid  in  1  sum_data valid.
sum_ready  out  1  framer idle and able to accept a word.
tx_en  out  1  one-cycle strobe to the transmitter enable input.
tx_data  out  PAYLOAD_BITS  byte to the transmitter data input; held stable from tx_en until busy falls.
tx_busy  in  1  transmitter busy flag.
frame_done  out  1  one-cycle pulse after the final byte has completed.
drop_count  out  8  saturating count of cycles where sum_valid=1 and sum_ready=0.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; sum_ready=1; tx_en=0; tx_data=0x00; frame_done=0; drop_count=0; shift/digit registers=0.
- DIGITS = SUM_WIDTH/4. The frame is DIGITS ASCII bytes, plus a terminator when enabled (see Optional Feature).
- Nibble→ASCII mapping: 0–9 → 0x30–0x39; 10–15 → 0x41–0x46 (uppercase).
- States:
  - IDLE: sum_ready=1. When sum_valid&sum_ready, capture sum_data into a shift register, clear byte_idx, go to ISSUE.
  - ISSUE: drive tx_data = ASCII(top nibble) or the terminator byte; tx_en=1 for exactly this cycle; go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1 (the transmitter raises busy one cycle after it samples enable), then go to WAIT_LO. tx_en stays 0.
  - WAIT_LO: wait for tx_busy=0. Then shift the register left by 4 and increment byte_idx.
    - If that byte was the last one, pulse frame_done and go to IDLE.
    - Otherwise go to ISSUE.
- Latency: tx_en rises 1 cycle after the accepting edge. Consecutive bytes are separated by at least 1 idle-busy cycle.
- tx_en is never asserted while tx_busy=1 or while in WAIT_*. ISSUE is entered only when tx_busy=0.
- If tx_busy is already 1 on entry to IDLE→ISSUE (an external user of the transmitter), ISSUE holds with tx_en=0 until tx_busy=0.
- sum_ready=0 in every non-IDLE state. A new word is never accepted mid-frame.
- drop_count increments each cycle with sum_valid=1 and sum_ready=0, and saturates at 0xFF. It is cleared only by reset.
- Simultaneous events: frame_done and re-acceptance cannot coincide; the first accept of a new word happens in the cycle after return to IDLE.
- Reset mid-frame: tx_en drops asynchronously; the frame is abandoned with no frame_done; the partially sent byte is the transmitter's concern.
- byte_idx width = $clog2(DIGITS+2)+1; no wrap possible.

Optional Feature:
Macro SUM_TX_CRLF_EN.
- Defined: after the DIGITS hex bytes, send 0x0D then 0x0A, using the same ISSUE/WAIT sequence. Frame length = DIGITS+2.
- Undefined: frame length = DIGITS; no terminator logic is synthesized.

Decomposition:
- Package sum_uart_pkg:
  - state encoding constants (IDLE=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3);
  - ASCII constants (ASCII_0=0x30, ASCII_A=0x41, ASCII_CR=0x0D, ASCII_LF=0x0A).
- One natural combinational sub-module: nibble_to_ascii (4-bit in, 8-bit out).

Test Plan:
- Reset: assert reset mid-cycle → outputs reach their reset values immediately without a clock edge; sum_ready=1, drop_count=0.
- Word 16'h1A2F with SUM_TX_CRLF_EN defined, behavioural transmitter model (busy 10 cycles) → bytes 0x31,0x41,0x32,0x46,0x0D,0x0A in order; one tx_en per byte; frame_done once; same word with macro undefined → 4 bytes only.
- Word 16'h0000 then 16'hFFFF back-to-back (valid held) → second is accepted only after the first frame_done; bytes 0x30×4 then 0x46×4.
- Hold sum_valid=1 for 300 cycles during a frame → drop_count saturates at 0xFF; no corruption of the in-flight frame.
- tx_busy forced high for 20 cycles before the accept → no tx_en until busy falls; then normal frame.
- Reset asserted while in WAIT_LO of the 2nd byte → tx_en=0, state=IDLE, no frame_done; a following 16'h00AB is sent correctly as 0x30,0x30,0x41,0x42.
